// File: rtl/fifo_pkg.sv
// Shared FIFO / UART transmit definitions: word width, frame size and the
// transmitter state encoding used by fifo_uart_tx.
package fifo_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} uart_tx_state_e;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a single-cycle tick on the last clock of every
// CLKS_PER_BIT-cycle bit period. Held at zero while clear is high so the
// first bit after clear is a full period.
module uart_baud_tick
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap at each bit boundary.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word, sends it as 8N1 frames,
// least-significant byte first, on a registered, idle-high tx line.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  input  logic                  full,
  output logic                  rd_en,
  output logic                  tx,
  output logic                  busy
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int BI_W           = cnt_width(BYTES_PER_WORD);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES_PER_WORD - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("fifo_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end

  uart_tx_state_e        state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [2:0]            bit_idx;
  logic [BI_W-1:0]       byte_idx;
  logic                  tick;
  logic                  baud_clear;
  logic                  unused_full;

  // The full flag has no role on the consumer side.
  assign unused_full = full;

  // Bit timing restarts from zero whenever a new word is being set up.
  assign baud_clear = (state == IDLE) || (state == FETCH);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // Pop only from IDLE; IDLE always exits to FETCH, so pops never repeat.
  assign rd_en = (state == IDLE) && !empty && !rst;

  // Transmit FSM; tx and busy are loaded with the value for the state being
  // entered, so the line changes in the same cycle as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          shreg    <= rd_data;
          byte_idx <= '0;
          bit_idx  <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            // Shifting on every bit leaves the next byte's LSB in shreg[0].
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 and 2 clocks per bit) fed from
// queue-backed FIFO models, checked cycle by cycle against a timeline model
// of the transmitter and by a UART receiver decoding the tx line.
module tb_fifo_uart_tx;

  localparam int CPB0 = 4;
  localparam int CPB1 = 2;
  localparam int BPW  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rd_data [2];
  logic        empty   [2];
  logic        full    [2];
  logic        rd_en   [2];
  logic        tx      [2];
  logic        busy    [2];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB0)) dut4 (
    .clk(clk), .rst(rst), .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]),
    .rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0])
  );

  fifo_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB1)) dut2 (
    .clk(clk), .rst(rst), .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]),
    .rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1])
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  bit          tr0 [$];
  bit          tr1 [$];
  logic [7:0]  rx [$];
  int          rdc [$];
  bit          force_e [2];
  bit          m_act   [2];
  int          m_start [2];
  int          m_next  [2];
  logic [15:0] m_word  [2];
  bit          prev_rd [2];
  bit          ex_rd_s [2];
  logic        obs_rd  [2];
  logic        obs_tx  [2];
  logic        obs_busy[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  // Expected line level: a word popped at cycle s occupies cycles s+2 onwards
  // with BPW frames of start, 8 data bits LSB first, stop.
  function automatic logic exp_tx(input int d, input int x);
    int fb, off, bi, pos;
    fb = 10 * cpb(d);
    if (!m_act[d] || x < m_start[d] + 2 || x >= m_next[d]) return 1'b1;
    off = x - m_start[d] - 2;
    bi  = off / fb;
    pos = (off % fb) / cpb(d);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_word[d][bi*8 + pos - 1];
  endfunction

  // One clock cycle: present inputs, sample and check at the falling edge,
  // then advance the model and the FIFO models after the rising edge.
  task automatic step();
    bit ex_busy;
    empty[0] = force_e[0] || (q0.size() == 0);
    empty[1] = force_e[1] || (q1.size() == 0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ex_rd_s[d]  = !rst && (cyc >= m_next[d]) && !empty[d];
      ex_busy     = m_act[d] && (cyc > m_start[d]) && (cyc < m_next[d]);
      obs_rd[d]   = rd_en[d];
      obs_tx[d]   = tx[d];
      obs_busy[d] = busy[d];
      chk($sformatf("rd_en d%0d c%0d", d, cyc), rd_en[d], ex_rd_s[d]);
      chk($sformatf("tx d%0d c%0d", d, cyc), tx[d], exp_tx(d, cyc));
      chk($sformatf("busy d%0d c%0d", d, cyc), busy[d], ex_busy);
      chk($sformatf("rd_en twice d%0d c%0d", d, cyc), (prev_rd[d] && rd_en[d] === 1'b1) ? 1 : 0, 0);
    end
    tr0.push_back(tx[0] === 1'b1);
    tr1.push_back(tx[1] === 1'b1);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_act[d]  = 1'b0;
        m_next[d] = cyc + 1;
      end else if (ex_rd_s[d]) begin
        m_act[d]   = 1'b1;
        m_start[d] = cyc;
        m_word[d]  = (d == 0) ? q0[0] : q1[0];
        m_next[d]  = cyc + 2 + BPW * 10 * cpb(d);
      end
      prev_rd[d] = (obs_rd[d] === 1'b1);
    end
    if (obs_rd[0] === 1'b1 && q0.size() > 0) rd_data[0] = q0.pop_front();
    if (obs_rd[1] === 1'b1 && q1.size() > 0) rd_data[1] = q1.pop_front();
    cyc++;
  endtask

  // Step until instance d has drained its FIFO and is idle; pops are logged.
  task automatic run_idle(input int d, input int maxc, input bit rnd_empty, output bit done);
    int n;
    n = 0;
    done = 1'b0;
    rdc.delete();
    while (!done && n < maxc) begin
      if (rnd_empty) force_e[d] = ($urandom % 2) == 1;
      step();
      n++;
      if (obs_rd[d] === 1'b1) rdc.push_back(cyc - 1);
      if (obs_busy[d] === 1'b0 && obs_rd[d] !== 1'b1 && ((d == 0) ? q0.size() : q1.size()) == 0)
        done = 1'b1;
    end
    force_e[d] = 1'b0;
  endtask

  // UART receiver: hunt for a low level, sample at mid-bit, check the stop bit.
  task automatic decode(input int d, output int ferr);
    bit tr [$];
    int c, i, mid;
    logic [7:0] b;
    if (d == 0) tr = tr0;
    else        tr = tr1;
    c = cpb(d);
    rx.delete();
    ferr = 0;
    i = 0;
    while (i < tr.size()) begin
      if (tr[i] == 1'b0) begin
        mid = i + c / 2;
        if (mid + 9 * c >= tr.size()) break;
        for (int k = 0; k < 8; k++) b[k] = tr[mid + (k + 1) * c];
        if (tr[mid + 9 * c] != 1'b1) ferr++;
        rx.push_back(b);
        i = mid + 9 * c + 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp [$]);
    chk({tag, " count"}, rx.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      if (k < rx.size()) chk($sformatf("%s byte%0d", tag, k), rx[k], exp[k]);
  endtask

  initial begin
    bit          done;
    int          ferr, c_rd, n, nrd, nzero;
    logic [15:0] w;
    logic [7:0]  expb [$];

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      force_e[d] = 1'b0; m_act[d] = 1'b0; m_start[d] = 0; m_next[d] = 0;
      m_word[d] = '0; prev_rd[d] = 1'b0; rd_data[d] = '0; full[d] = 1'b0;
    end

    // Reset held three cycles with a word waiting.
    q0.push_back(16'hA55A);
    repeat (3) begin
      step();
      chk("reset rd_en", obs_rd[0], 1'b0);
      chk("reset tx", obs_tx[0], 1'b1);
      chk("reset busy", obs_busy[0], 1'b0);
    end
    rst = 1'b0;
    tr0.delete();

    // Single word 0xA55A: pop on first cycle, busy drops 82 cycles later.
    step();
    chk("pop after reset", obs_rd[0], 1'b1);
    c_rd = cyc - 1;
    step();
    n = 0;
    while (obs_busy[0] !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("busy fall latency", (cyc - 1) - c_rd, 82);
    decode(0, ferr);
    chk("A55A framing", ferr, 0);
    expb = '{8'h5A, 8'hA5};
    chk_bytes("A55A", expb);

    // Two queued words: two pops, one word period plus two idle cycles apart.
    tr0.delete();
    q0.push_back(16'h0001);
    q0.push_back(16'hFFFF);
    run_idle(0, 600, 1'b0, done);
    chk("two words idle", done, 1'b1);
    chk("two words pops", rdc.size(), 2);
    if (rdc.size() == 2) chk("pop spacing", rdc[1] - rdc[0], 2 + BPW * 10 * CPB0);
    decode(0, ferr);
    chk("two words framing", ferr, 0);
    expb = '{8'h01, 8'h00, 8'hFF, 8'hFF};
    chk_bytes("two words", expb);

    // FIFO empty for 100 cycles: nothing happens.
    tr0.delete();
    nrd = 0;
    repeat (100) begin
      step();
      if (obs_rd[0] === 1'b1) nrd++;
    end
    nzero = 0;
    foreach (tr0[k]) if (tr0[k] == 1'b0) nzero++;
    chk("empty pops", nrd, 0);
    chk("empty tx low cycles", nzero, 0);

    // Reset during bit 3 of the second byte, then a clean next word.
    q0.push_back(16'h1234);
    q0.push_back(16'hBEEF);
    n = 0;
    step();
    while (obs_rd[0] !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    c_rd = cyc - 1;
    n = 0;
    while (cyc < c_rd + 2 + 10 * CPB0 + 4 * CPB0 && n < 200) begin
      step();
      n++;
    end
    chk("pre-reset busy", obs_busy[0], 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tr0.delete();
    step();
    chk("post-reset tx", obs_tx[0], 1'b1);
    chk("post-reset busy", obs_busy[0], 1'b0);
    chk("post-reset pop", obs_rd[0], 1'b1);
    run_idle(0, 400, 1'b0, done);
    chk("post-reset idle", done, 1'b1);
    decode(0, ferr);
    chk("post-reset framing", ferr, 0);
    expb = '{8'hEF, 8'hBE};
    chk_bytes("post-reset", expb);

    // Two clocks per bit, random words, empty toggled randomly every cycle.
    tr1.delete();
    expb.delete();
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom);
      q1.push_back(w);
      expb.push_back(w[7:0]);
      expb.push_back(w[15:8]);
    end
    run_idle(1, 3000, 1'b1, done);
    chk("random idle", done, 1'b1);
    chk("random pops", rdc.size(), 6);
    decode(1, ferr);
    chk("random framing", ferr, 0);
    chk_bytes("random", expb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
